myproject_mac_acc: RTL and testbench

- Accumulation stage directly downstream of the dense-layer 9-bit-unsigned × 7-bit-signed multiplier, which produces a 16-bit signed product.
- Sums N_IN consecutive products belonging to one output neuron, seeded with that neuron's bias.
- Rescales the sum by an arithmetic right shift, narrows it to the layer output width, and presents one result per neuron on a valid/ready interface.

---
 rtl/myproject_mac_pkg.sv | 58 +++++
 rtl/myproject_mac_narrow.sv | 29 ++
 rtl/myproject_mac_acc.sv | 136 +++++++++++++
 tb/tb_myproject_mac_acc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/myproject_mac_pkg.sv
// Shared types and helpers for the dense-layer accumulate stages.
package myproject_mac_pkg;

  // Accumulating products, or presenting a finished neuron result.
  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_e;

  // Result of narrow(): 64-bit value (callers keep the low bits) plus a clamp indicator.
  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } narrow_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Accumulator width that cannot overflow for n_in products plus one bias.
  function automatic int unsigned calc_acc_w(input int unsigned prod_w,
                                             input int unsigned bias_w,
                                             input int unsigned n_in);
    return ((prod_w > bias_w) ? prod_w : bias_w) + clog2(n_in) + 1;
  endfunction

  // Floor-shift a signed value, then either leave it for wrap truncation by the caller
  // or clamp it into the signed out_w range.
  function automatic narrow_t narrow(input logic signed [63:0] val,
                                     input int unsigned        shift,
                                     input int unsigned        out_w,
                                     input bit                 sat_en);
    narrow_t            r;
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s     = val >>> shift;
    hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (out_w - 1));
    r.sat = 1'b0;
    r.val = s;
    if (sat_en) begin
      if (s > hi) begin
        r.val = hi;
        r.sat = 1'b1;
      end else if (s < lo) begin
        r.val = lo;
        r.sat = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/myproject_mac_narrow.sv
// Combinational rescale of an accumulator value: arithmetic shift, then wrap or clamp
// to OUT_W bits. Supports ACC_W <= 64 and OUT_W < 64.
module myproject_mac_narrow
  import myproject_mac_pkg::*;
#(
  parameter int unsigned ACC_W  = 21,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 4,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] res_o,
  output logic             sat_o
);

  narrow_t nr;
  logic    unused_hi;

  // Sign-extend to the helper's working width and narrow.
  always_comb begin
    nr = narrow(64'($signed(acc_i)), SHIFT, OUT_W, SAT_EN);
  end

  assign res_o     = nr.val[OUT_W-1:0];
  assign sat_o     = nr.sat;
  // Upper bits are discarded by design (two's-complement wrap).
  assign unused_hi = ^nr.val[63:OUT_W];

endmodule

// File: rtl/myproject_mac_acc.sv
// Accumulation stage after the dense-layer multiplier: sums N_IN signed products seeded
// with a per-neuron bias, rescales by SHIFT and emits one result per neuron on valid/ready.
// Optional macro MYPROJECT_ACC_SAT_EN: saturate instead of wrap and expose sticky sat_flag.
module myproject_mac_acc
  import myproject_mac_pkg::*;
#(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned N_IN   = 16,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 4
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [PROD_W-1:0]      prod_data,
  input  logic                   prod_valid,
  output logic                   prod_ready,
  input  logic [BIAS_W-1:0]      bias_data,
  output logic [OUT_W-1:0]       res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [clog2(N_IN)-1:0] grp_cnt
`ifdef MYPROJECT_ACC_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int unsigned     AccW    = calc_acc_w(PROD_W, BIAS_W, N_IN);
  localparam int unsigned     CntW    = clog2(N_IN);
  localparam logic [CntW-1:0] CntLast = CntW'(N_IN - 1);
`ifdef MYPROJECT_ACC_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic signed [AccW-1:0] sum;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [OUT_W-1:0]       res_q, res_d;
  logic [OUT_W-1:0]       narrow_res;
  logic                   narrow_sat;
  logic                   prod_fire;
  logic                   last_fire;

  // Gated by reset so nothing is accepted during the reset cycle.
  assign prod_ready = (state_q == S_ACC) && !ap_rst;
  assign res_valid  = (state_q == S_OUT);
  assign prod_fire  = prod_valid && prod_ready;
  assign last_fire  = prod_fire && (cnt_q == CntLast);
  assign res_data   = res_q;
  assign grp_cnt    = cnt_q;

  // Sum including the product on the bus; the first product of a group is seeded by the bias.
  always_comb begin
    if (cnt_q == '0) begin
      sum = AccW'($signed(bias_data)) + AccW'($signed(prod_data));
    end else begin
      sum = acc_q + AccW'($signed(prod_data));
    end
  end

  myproject_mac_narrow #(
    .ACC_W  (AccW),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT),
    .SAT_EN (SatEn)
  ) u_narrow (
    .acc_i (sum),
    .res_o (narrow_res),
    .sat_o (narrow_sat)
  );

  // Next-state: accumulate on each accepted product, latch the result on the last one.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      S_ACC: begin
        if (prod_fire) begin
          acc_d = sum;
          if (last_fire) begin
            cnt_d   = '0;
            res_d   = narrow_res;
            state_d = S_OUT;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      S_OUT: begin
        if (res_ready) state_d = S_ACC;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

`ifdef MYPROJECT_ACC_SAT_EN
  logic sat_q, sat_d;

  // Sticky clamp indicator; only reset clears it.
  always_comb begin
    sat_d = sat_q | (last_fire & narrow_sat);
  end

  // Clamp indicator register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`else
  logic unused_sat;
  assign unused_sat = narrow_sat;
`endif

endmodule

// File: tb/tb_myproject_mac_acc.sv
// Self-checking bench for myproject_mac_acc: a default instance (SHIFT=4) and a SHIFT=0
// instance share one stimulus stream. Honours MYPROJECT_ACC_SAT_EN.
module tb_myproject_mac_acc;

  localparam int NIn = 16;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [15:0] prod_data;
  logic        prod_valid;
  logic [15:0] bias_data;
  logic        res_ready;
  logic        prod_ready4, prod_ready0;
  logic [15:0] res_data4, res_data0;
  logic        res_valid4, res_valid0;
  logic [3:0]  grp_cnt4, grp_cnt0;
`ifdef MYPROJECT_ACC_SAT_EN
  logic        sat4, sat0;
  bit          exp_sat4, exp_sat0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  int grp[NIn];
  int grp_bias;

  typedef struct {
    int bias;
    int pa;     // products at even positions
    int pb;     // products at odd positions
    int exp4;
    int exp0;
    bit sat4;
    bit sat0;
    int stall;
  } vec_t;

  vec_t vecs[7];

  always #5 ap_clk = ~ap_clk;

  myproject_mac_acc #(.SHIFT(4)) dut4 (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready4),
    .bias_data  (bias_data),
    .res_data   (res_data4),
    .res_valid  (res_valid4),
    .res_ready  (res_ready),
    .grp_cnt    (grp_cnt4)
`ifdef MYPROJECT_ACC_SAT_EN
    ,
    .sat_flag   (sat4)
`endif
  );

  myproject_mac_acc #(.SHIFT(0)) dut0 (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready0),
    .bias_data  (bias_data),
    .res_data   (res_data0),
    .res_valid  (res_valid0),
    .res_ready  (res_ready),
    .grp_cnt    (grp_cnt0)
`ifdef MYPROJECT_ACC_SAT_EN
    ,
    .sat_flag   (sat0)
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: floor(sum / 2^shift), then 16-bit wrap or clamp.
  function automatic int model_res(input longint sum, input int shift, output bit sat);
    longint d, q;
    d   = longint'(1) << shift;
    q   = sum / d;
    if ((sum % d != 0) && (sum < 0)) q = q - 1;
    sat = 1'b0;
`ifdef MYPROJECT_ACC_SAT_EN
    if (q > 32767) begin
      q   = 32767;
      sat = 1'b1;
    end else if (q < -32768) begin
      q   = -32768;
      sat = 1'b1;
    end
`else
    q = ((q % 65536) + 65536) % 65536;
    if (q >= 32768) q = q - 65536;
`endif
    return int'(q);
  endfunction

  task automatic do_reset();
    @(negedge ap_clk);
    prod_valid = 1'b0;
    ap_rst     = 1'b1;
    #1;
    chk("rst_prod_ready", prod_ready4, 0);
    @(negedge ap_clk);
    chk("rst_res_valid", res_valid4, 0);
    chk("rst_res_data", res_data4, 0);
    chk("rst_grp_cnt", grp_cnt4, 0);
    chk("rst_res_valid0", res_valid0, 0);
`ifdef MYPROJECT_ACC_SAT_EN
    chk("rst_sat4", sat4, 0);
    chk("rst_sat0", sat0, 0);
    exp_sat4 = 1'b0;
    exp_sat0 = 1'b0;
`endif
    ap_rst = 1'b0;
    #1;
    chk("post_rst_prod_ready", prod_ready4, 1);
  endtask

  // Offer n products from grp[], optionally with random bubbles and a scrambled bias.
  task automatic run_group(input int n, input int gap_pct, input bit scramble);
    int idx    = 0;
    int budget = 0;
    while (idx < n) begin
      @(negedge ap_clk);
      budget++;
      if (budget > 1000) begin
        chk("grp_timeout", idx, n);
        break;
      end
      if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        prod_valid = 1'b0;
        prod_data  = 16'($urandom);
        bias_data  = 16'($urandom);
      end else begin
        prod_valid = 1'b1;
        prod_data  = 16'(grp[idx]);
        bias_data  = (idx == 0 || !scramble) ? 16'(grp_bias) : 16'($urandom);
        if (prod_ready4) begin
          chk("grp_cnt", grp_cnt4, idx);
          chk("grp_cnt0", grp_cnt0, idx);
          chk("res_valid_early", res_valid4, 0);
          idx++;
        end
      end
    end
  endtask

  // Called right after the last product was set up; checks result timing and hold.
  task automatic collect(input int e4, input int e0, input bit s4, input bit s0,
                         input int stall);
    @(negedge ap_clk);
    prod_valid = 1'b0;
    res_ready  = (stall == 0);
    chk("res_valid", res_valid4, 1);
    chk("res_valid0", res_valid0, 1);
    chk("res_data_s4", $signed(res_data4), e4);
    chk("res_data_s0", $signed(res_data0), e0);
    chk("grp_cnt_wrap", grp_cnt4, 0);
    chk("prod_ready_out", prod_ready4, 0);
`ifdef MYPROJECT_ACC_SAT_EN
    exp_sat4 = exp_sat4 | s4;
    exp_sat0 = exp_sat0 | s0;
    chk("sat_flag4", sat4, exp_sat4);
    chk("sat_flag0", sat0, exp_sat0);
`else
    if (s4 || s0) chk("sat_unexpected", 1, 0);
`endif
    for (int i = 0; i < stall; i++) begin
      @(negedge ap_clk);
      chk("stall_valid", res_valid4, 1);
      chk("stall_data", $signed(res_data4), e4);
      chk("stall_prod_ready", prod_ready4, 0);
      if (i == stall - 1) res_ready = 1'b1;
    end
    @(negedge ap_clk);
    chk("xfer_valid", res_valid4, 0);
    chk("xfer_prod_ready", prod_ready4, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst     = 1'b1;
    prod_valid = 1'b0;
    prod_data  = '0;
    bias_data  = '0;
    res_ready  = 1'b1;
`ifdef MYPROJECT_ACC_SAT_EN
    exp_sat4   = 1'b0;
    exp_sat0   = 1'b0;
`endif

    //          bias    pa      pb      exp4    exp0    s4 s0 stall
    vecs[0] = '{10,     3,      3,      3,      58,     0, 0, 0};
    vecs[1] = '{-5,     -100,   20,     -41,    -645,   0, 0, 7};
`ifdef MYPROJECT_ACC_SAT_EN
    vecs[2] = '{0,      32767,  32767,  32767,  32767,  0, 1, 0};
    vecs[4] = '{-32768, -32768, -32768, -32768, -32768, 1, 1, 0};
`else
    vecs[2] = '{0,      32767,  32767,  32767,  -16,    0, 0, 0};
    vecs[4] = '{-32768, -32768, -32768, 30720,  -32768, 0, 0, 0};
`endif
    vecs[3] = '{0,      1,      1,      1,      16,     0, 0, 1};
    vecs[5] = '{100,    7,      -7,     6,      100,    0, 0, 2};
    vecs[6] = '{1,      -1,     -1,     -1,     -15,    0, 0, 0};

    do_reset();

    // Directed vectors; odd entries run with bubbles and a scrambled mid-group bias.
    for (int i = 0; i < 7; i++) begin
      grp_bias = vecs[i].bias;
      for (int k = 0; k < NIn; k++) grp[k] = (k % 2 == 0) ? vecs[i].pa : vecs[i].pb;
      run_group(NIn, (i % 2) * 40, (i % 2) == 1);
      collect(vecs[i].exp4, vecs[i].exp0, vecs[i].sat4, vecs[i].sat0, vecs[i].stall);
    end

    // Reset mid-group: nine products are discarded, the next group starts from scratch.
    grp_bias = 7;
    for (int k = 0; k < NIn; k++) grp[k] = 50;
    run_group(9, 0, 1'b0);
    @(negedge ap_clk);
    prod_valid = 1'b0;
    chk("mid_grp_cnt", grp_cnt4, 9);
    do_reset();
    grp_bias = 0;
    for (int k = 0; k < NIn; k++) grp[k] = 1;
    run_group(NIn, 0, 1'b0);
    collect(1, 16, 1'b0, 1'b0, 0);

    // Randomized groups against the arithmetic model.
    for (int g = 0; g < 20; g++) begin
      longint sum;
      int     e4, e0;
      bit     s4, s0;
      grp_bias = int'($urandom_range(0, 65535)) - 32768;
      sum      = grp_bias;
      for (int k = 0; k < NIn; k++) begin
        if ($urandom_range(0, 1) == 0) grp[k] = int'($urandom_range(0, 65535)) - 32768;
        else                           grp[k] = int'($urandom_range(0, 400)) - 200;
        sum += grp[k];
      end
      e4 = model_res(sum, 4, s4);
      e0 = model_res(sum, 0, s0);
      run_group(NIn, int'($urandom_range(0, 50)), 1'b1);
      collect(e4, e0, s4, s0, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
